// File: rtl/rf_pkg.sv
// Shared types and default sizes for the parametrised register file.
package rf_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_SWEEP = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W = 16;
    localparam int RF_ADDR_W = 3;

endpackage

// File: rtl/rf_clear_ctrl.sv
// Clear sequencer: once started, it walks every entry in ascending order and issues a zero write to each.
// The current FSM state is brought out on a port so it can be observed directly.
module rf_clear_ctrl
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output rf_state_e         state
);

    rf_state_e         state_next;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RF_IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // A CLR seen during a sweep is ignored, so a sweep always covers exactly DEPTH entries.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        busy       = 1'b0;
        clr_we     = 1'b0;
        unique case (state)
            RF_IDLE: begin
                if (clr) begin
                    state_next = RF_SWEEP;
                    idx_next   = '0;
                end
            end
            RF_SWEEP: begin
                busy     = 1'b1;
                clr_we   = 1'b1;
                idx_next = idx + 1'b1;
                if (&idx) begin
                    state_next = RF_IDLE;
                end
            end
            default: state_next = RF_IDLE;
        endcase
    end

    assign clr_addr = idx;

endmodule

// File: rtl/register_file_param.sv
// Register array of DEPTH x DATA_W with one write port and two read ports.
// Options: a hardwired-zero register 0, same-cycle write bypass, registered reads, and a clear sweep.
module register_file_param
    import rf_pkg::*;
#(
    parameter int DATA_W    = RF_DATA_W,
    parameter int ADDR_W    = RF_ADDR_W,
    parameter int ZERO_REG  = 0,
    parameter int BYPASS    = 1,
    parameter int SYNC_READ = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WR_addr,
    input  logic [DATA_W-1:0] WR_data,
    input  logic [ADDR_W-1:0] RA_addr,
    input  logic [ADDR_W-1:0] RB_addr,
    output logic [DATA_W-1:0] RA_data,
    output logic [DATA_W-1:0] RB_data,
    input  logic              CLR,
    output logic              BUSY,
    output logic              WR_err
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    rf_state_e         clr_state;

    rf_clear_ctrl #(.ADDR_W(ADDR_W)) u_clear_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (CLR),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .state    (clr_state)
    );

    logic              accepted;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    assign accepted = WE && (clr_state != RF_SWEEP) && !((ZERO_REG != 0) && (WR_addr == '0));

    // The sweep owns the write port while it runs. User writes are never accepted at the same time.
    assign wr_en   = clr_we | accepted;
    assign wr_addr = clr_we ? clr_addr : WR_addr;
    assign wr_data = clr_we ? '0 : WR_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            WR_err <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
            WR_err <= WE & busy;
        end
    end

    assign BUSY = busy;

    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

    // The zero-register override is applied last, so it takes priority over the bypass.
    always_comb begin
        sel_a = mem[RA_addr];
        sel_b = mem[RB_addr];
        if ((BYPASS != 0) && accepted && (WR_addr == RA_addr)) sel_a = WR_data;
        if ((BYPASS != 0) && accepted && (WR_addr == RB_addr)) sel_b = WR_data;
        if ((ZERO_REG != 0) && (RA_addr == '0)) sel_a = '0;
        if ((ZERO_REG != 0) && (RB_addr == '0)) sel_b = '0;
    end

    generate
        if (SYNC_READ != 0) begin : g_sync_read
            logic [DATA_W-1:0] ra_q;
            logic [DATA_W-1:0] rb_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ra_q <= '0;
                    rb_q <= '0;
                end else begin
                    ra_q <= sel_a;
                    rb_q <= sel_b;
                end
            end
            assign RA_data = ra_q;
            assign RB_data = rb_q;
        end else begin : g_comb_read
            assign RA_data = sel_a;
            assign RB_data = sel_b;
        end
    endgenerate

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param. Three instances share one stimulus: the default configuration,
// a zero-register configuration without bypass, and a configuration with registered reads.
module tb_register_file_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        WE;
    logic [2:0]  WR_addr;
    logic [15:0] WR_data;
    logic [2:0]  RA_addr;
    logic [2:0]  RB_addr;
    logic        CLR;

    logic [15:0] d_ra, d_rb, z_ra, z_rb, s_ra, s_rb;
    logic        d_busy, z_busy, s_busy, d_err, z_err, s_err;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    register_file_param u_def (
        .clk(clk), .rst_n(rst_n), .WE(WE), .WR_addr(WR_addr), .WR_data(WR_data),
        .RA_addr(RA_addr), .RB_addr(RB_addr), .RA_data(d_ra), .RB_data(d_rb),
        .CLR(CLR), .BUSY(d_busy), .WR_err(d_err)
    );

    register_file_param #(.ZERO_REG(1), .BYPASS(0)) u_zero (
        .clk(clk), .rst_n(rst_n), .WE(WE), .WR_addr(WR_addr), .WR_data(WR_data),
        .RA_addr(RA_addr), .RB_addr(RB_addr), .RA_data(z_ra), .RB_data(z_rb),
        .CLR(CLR), .BUSY(z_busy), .WR_err(z_err)
    );

    register_file_param #(.SYNC_READ(1)) u_sync (
        .clk(clk), .rst_n(rst_n), .WE(WE), .WR_addr(WR_addr), .WR_data(WR_data),
        .RA_addr(RA_addr), .RB_addr(RB_addr), .RA_data(s_ra), .RB_data(s_rb),
        .CLR(CLR), .BUSY(s_busy), .WR_err(s_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_write(input logic we, input logic [2:0] a, input logic [15:0] d);
        WE      = we;
        WR_addr = a;
        WR_data = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cnt;
        logic [15:0] v;

        rst_n = 1'b0; WE = 1'b0; WR_addr = '0; WR_data = '0;
        RA_addr = '0; RB_addr = '0; CLR = 1'b0;
        #3;
        check("rst_def_ra", d_ra, 16'h0);
        check("rst_def_busy", d_busy, 1'b0);
        check("rst_def_err", d_err, 1'b0);
        check("rst_sync_rb", s_rb, 16'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic writes to entries 0 and 1, then read both ports
        tick(); drive_write(1'b1, 3'd0, 16'hABCD);
        tick(); drive_write(1'b1, 3'd1, 16'h0123);
        tick(); drive_write(1'b0, 3'd0, 16'h0);
        RA_addr = 3'd0; RB_addr = 3'd1;
        #1;
        check("def_ra_0", d_ra, 16'hABCD);
        check("def_rb_1", d_rb, 16'h0123);
        check("zero_ra_0", z_ra, 16'h0);
        check("zero_rb_1", z_rb, 16'h0123);
        tick();
        check("sync_ra_0", s_ra, 16'hABCD);
        check("sync_rb_1", s_rb, 16'h0123);

        // Same-cycle bypass vs no bypass
        drive_write(1'b1, 3'd3, 16'h5A5A); RA_addr = 3'd3;
        #1;
        check("def_bypass_ra3", d_ra, 16'h5A5A);
        check("zero_nobypass_ra3", z_ra, 16'h0);
        tick(); drive_write(1'b0, 3'd0, 16'h0);
        #1;
        check("zero_after_edge_ra3", z_ra, 16'h5A5A);
        check("def_after_edge_ra3", d_ra, 16'h5A5A);

        // Hardwired zero register
        drive_write(1'b1, 3'd0, 16'hFFFF); RA_addr = 3'd0;
        #1;
        check("zero_reg_comb", z_ra, 16'h0);
        check("def_bypass_ra0", d_ra, 16'hFFFF);
        tick(); drive_write(1'b0, 3'd0, 16'h0);
        #1;
        check("zero_reg_after", z_ra, 16'h0);
        check("zero_reg_no_err", z_err, 1'b0);
        check("def_ra0_ffff", d_ra, 16'hFFFF);
        drive_write(1'b1, 3'd7, 16'hFFFF); RA_addr = 3'd7;
        tick(); drive_write(1'b0, 3'd0, 16'h0);
        #1;
        check("zero_ra7", z_ra, 16'hFFFF);

        // Registered read: latency and bypass through the register
        RB_addr = 3'd1;
        tick();
        drive_write(1'b1, 3'd2, 16'hBEEF); RB_addr = 3'd2;
        #1;
        check("sync_rb_pre_edge", s_rb, 16'h0123);
        tick(); drive_write(1'b0, 3'd0, 16'h0);
        #1;
        check("sync_rb_bypass", s_rb, 16'hBEEF);
        check("def_rb2", d_rb, 16'hBEEF);

        // Fill all entries and read them back
        for (int i = 0; i < 8; i++) begin
            v = 16'h1111 * 16'(i + 1);
            drive_write(1'b1, 3'(i), v);
            exp_q.push_back(v);
            tick();
        end
        drive_write(1'b0, 3'd0, 16'h0);
        for (int i = 0; i < 8; i++) begin
            RA_addr = 3'(i);
            #1;
            check($sformatf("fill_ra%0d", i), d_ra, exp_q.pop_front());
        end

        // Clear sweep with a dropped write and an ignored CLR
        RA_addr = 3'd5; RB_addr = 3'd1;
        check("busy_before_clr", d_busy, 1'b0);
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (d_busy) busy_cnt++;
            if (c == 0) check("busy_first", d_busy, 1'b1);
            if (c == 2) begin
                drive_write(1'b1, 3'd6, 16'h7777);
                CLR = 1'b1;
            end
            if (c == 3) begin
                drive_write(1'b0, 3'd0, 16'h0);
                CLR = 1'b0;
                check("wr_err_pulse", d_err, 1'b1);
            end
            if (c == 4) begin
                #1;
                check("wr_err_one_cycle", d_err, 1'b0);
                check("sweep_live_ra5", d_ra, 16'h6666);
                check("sweep_live_rb1", d_rb, 16'h0);
            end
            tick();
        end
        check("busy_cycles", busy_cnt, 8);
        for (int i = 0; i < 8; i++) exp_q.push_back(16'h0);
        for (int i = 0; i < 8; i++) begin
            RA_addr = 3'(i);
            #1;
            check($sformatf("cleared_ra%0d", i), d_ra, exp_q.pop_front());
        end

        // Reset during a sweep
        drive_write(1'b1, 3'd4, 16'h1234);
        tick(); drive_write(1'b0, 3'd0, 16'h0);
        CLR = 1'b1;
        tick(); CLR = 1'b0;
        tick(); tick(); tick();
        RA_addr = 3'd4; RB_addr = 3'd4;
        #1;
        check("mid_sweep_ra4", d_ra, 16'h1234);
        check("mid_sweep_busy", d_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", d_busy, 1'b0);
        check("abort_ra4", d_ra, 16'h0);
        check("abort_sync_rb", s_rb, 16'h0);
        tick();
        rst_n = 1'b1;
        tick();
        drive_write(1'b1, 3'd5, 16'h00AA);
        tick(); drive_write(1'b0, 3'd0, 16'h0);
        RA_addr = 3'd5;
        #1;
        check("post_reset_ra5", d_ra, 16'h00AA);
        check("post_reset_busy", d_busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
